// File: rtl/hazard_pkg.sv
// Shared types and helpers for the pipeline hazard/forwarding controller.
// Tag fields are sized by the TAG_* constants; the controller's NSRC/REGW/AVW must match them.
package hazard_pkg;

    localparam int TAG_NSRC = 2;
    localparam int TAG_REGW = 5;
    localparam int TAG_AVW  = 2;
    localparam int FWD_RF   = 0;

    typedef struct packed {
        logic                               valid;
        logic [TAG_REGW-1:0]                rd;
        logic                               wr;
        logic [TAG_AVW-1:0]                 avail;
        logic [TAG_NSRC-1:0][TAG_REGW-1:0]  rs;
    } tag_t;

    function automatic int fwd_sel_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Writes to x0 never produce a dependency.
    function automatic logic tag_match(input tag_t t, input logic [TAG_REGW-1:0] r);
        return t.valid && t.wr && (t.rd == r) && (r != '0);
    endfunction

endpackage

// File: rtl/hazard_tag_pipe.sv
// Shadow shift register of destination tags, one entry per post-decode stage.
// Freezes as a whole; stage 1 loads either the decode tag or an empty bubble.
module hazard_tag_pipe
    import hazard_pkg::*;
#(
    parameter int DEPTH = 3
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               freeze,
    input  logic               bubble,
    input  tag_t               in_tag,
    output tag_t [DEPTH:1]     stage
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stage <= '0;
        end else if (!freeze) begin
            stage[1] <= bubble ? tag_t'('0) : in_tag;
            for (int k = 2; k <= DEPTH; k++) begin
                stage[k] <= stage[k-1];
            end
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush/forward controller for the in-order pipeline, driven by a shadow
// pipeline of destination tags, plus saturating stall and flush event counters.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int DEPTH = 3,
    parameter int NSRC  = TAG_NSRC,
    parameter int REGW  = TAG_REGW,
    parameter int AVW   = TAG_AVW,
    parameter int CNTW  = 32
) (
    input  logic                                clk,
    input  logic                                reset_n,
    input  logic                                ValidD,
    input  logic [NSRC*REGW-1:0]                RsD,
    input  logic [REGW-1:0]                     RdD,
    input  logic                                RegWriteD,
    input  logic [AVW-1:0]                      AvailD,
    input  logic                                BranchTakenE,
    input  logic                                HoldM,
    output logic                                StallF,
    output logic                                StallD,
    output logic                                StallE,
    output logic                                FlushD,
    output logic                                FlushE,
    output logic [NSRC*fwd_sel_w(DEPTH)-1:0]    FwdE,
    output logic [CNTW-1:0]                     StallCount,
    output logic [CNTW-1:0]                     FlushCount
);

    localparam int FW = fwd_sel_w(DEPTH);

    tag_t                       d_tag;
    tag_t [DEPTH:1]             stage;
    logic                       load_use;
    logic                       slow;
    logic [NSRC-1:0][FW-1:0]    fwd_sel;
    logic                       unused_tag_bits;

    always_comb begin
        d_tag       = '0;
        d_tag.valid = ValidD;
        d_tag.rd    = RdD;
        d_tag.wr    = RegWriteD;
        d_tag.avail = AvailD;
        for (int i = 0; i < NSRC; i++) begin
            d_tag.rs[i] = RsD[i*REGW +: REGW];
        end
    end

    hazard_tag_pipe #(
        .DEPTH (DEPTH)
    ) u_tag_pipe (
        .clk     (clk),
        .reset_n (reset_n),
        .freeze  (HoldM),
        .bubble  (FlushE || !ValidD),
        .in_tag  (d_tag),
        .stage   (stage)
    );

    // Only the youngest writer of each source decides; older writers are shadowed by it.
    always_comb begin
        load_use = 1'b0;
        slow     = 1'b0;
        for (int i = 0; i < NSRC; i++) begin
            slow = 1'b0;
            for (int k = DEPTH - 1; k >= 1; k--) begin
                if (tag_match(stage[k], d_tag.rs[i])) begin
                    slow = (int'(stage[k].avail) > k + 1);
                end
            end
            load_use = load_use | slow;
        end
    end

    always_comb begin
        for (int i = 0; i < NSRC; i++) begin
            fwd_sel[i] = FW'(FWD_RF);
            for (int k = DEPTH; k >= 2; k--) begin
                if (tag_match(stage[k], stage[1].rs[i])) begin
                    fwd_sel[i] = FW'(k);
                end
            end
        end
    end

    assign FwdE = fwd_sel;

    // Reset forces every control output low regardless of HoldM or a pending branch.
    always_comb begin
        StallF = 1'b0;
        StallD = 1'b0;
        StallE = 1'b0;
        FlushD = 1'b0;
        FlushE = 1'b0;
        if (!reset_n) begin
            StallF = 1'b0;
        end else if (HoldM) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
        end else if (BranchTakenE) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
        end else if (load_use) begin
            StallF = 1'b1;
            StallD = 1'b1;
            FlushE = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            StallCount <= '0;
            FlushCount <= '0;
        end else begin
            if (StallD && (StallCount != '1)) begin
                StallCount <= StallCount + 1'b1;
            end
            if (FlushD && (FlushCount != '1)) begin
                FlushCount <= FlushCount + 1'b1;
            end
        end
    end

    // Sources of older stages and the availability of the last stage are carried but never read.
    assign unused_tag_bits = ^stage;

endmodule
